lsu_ctrl: RTL

Load/store sequencer between the execute stage and the single-port data memory bus.
- Accepts one access per request; checks alignment; generates word address, byte enables and lane-replicated store data.
- Runs the bus req/gnt/rvalid handshake, then returns a sign/zero-extended load result or a store acknowledge.
- Stalls the pipeline via req_ready while an access is in flight.

---
 rtl/lsu_pkg.sv | 70 +++++++
 rtl/lsu_load_format.sv | 36 +++
 rtl/lsu_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store sequencer: funct3 codes, FSM
// encoding, byte-enable patterns and the access decode helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_B0   = 4'b0001;
  localparam logic [3:0] BE_H_LO = 4'b0011;
  localparam logic [3:0] BE_H_HI = 4'b1100;
  localparam logic [3:0] BE_W    = 4'b1111;

  // Unused encodings, plus unsigned variants that make no sense for stores.
  function automatic logic access_illegal(input logic store, input logic [2:0] f3);
    logic bad;
    bad = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: bad = 1'b0;
      F3_BU, F3_HU:     bad = store;
      default:          bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic access_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (f3)
      F3_H, F3_HU: mis = off[0];
      F3_W:        mis = (off != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Byte enables depend only on width (f3[1:0]) and the lane offset.
  function automatic logic [3:0] access_be(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = BE_B0 << off;
      2'b01:   be = off[1] ? BE_H_HI : BE_H_LO;
      2'b10:   be = BE_W;
      default: be = BE_NONE;
    endcase
    return be;
  endfunction

  // Replicate the low byte/halfword across all lanes so the bus can pick any.
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wdata);
    logic [31:0] d;
    case (f3[1:0])
      2'b00:   d = {4{wdata[7:0]}};
      2'b01:   d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/lsu_load_format.sv
// Load result formatting: selects the addressed byte/halfword lane from the
// raw bus word and sign- or zero-extends it according to funct3.
module lsu_load_format
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select then extend; W and anything unexpected pass the word through.
  always_comb begin
    byte_sel = rdata[7:0];
    case (offset)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    data = rdata;
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'h000000, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'h0000, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between execute and the single-port data bus.
// Optional build macro LSU_TIMEOUT_EN adds a bus-timeout error after
// TIMEOUT_CYCLES cycles spent in REQ or WAIT.
//
// state | meaning
// IDLE  | ready for a new access (req_ready=1)
// REQ   | mem_req held with stable bus fields until mem_gnt
// WAIT  | granted, waiting for mem_rvalid
// RESP  | result captured; rsp_valid pulses as we return to IDLE
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  output logic              rsp_err
);

  lsu_state_e  state;
  logic        store_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        err_q;
  logic [31:0] load_data;
  logic        req_bad;

  assign req_bad = access_illegal(req_store, req_funct3) ||
                   access_misaligned(req_funct3, req_addr[1:0]);

  lsu_load_format u_load_format (
    .rdata  (mem_rdata),
    .offset (off_q),
    .funct3 (f3_q),
    .data   (load_data)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt;
  logic             expired;
  assign expired = (cnt == CNT_LAST);
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
`endif

  // Sequencing FSM; every output is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= BE_NONE;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      store_q   <= 1'b0;
      f3_q      <= F3_B;
      off_q     <= 2'b00;
      err_q     <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt       <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            store_q   <= req_store;
            f3_q      <= req_funct3;
            off_q     <= req_addr[1:0];
            req_ready <= 1'b0;
            if (req_bad) begin
              err_q    <= 1'b1;
              rsp_data <= '0;
              state    <= ST_RESP;
            end else begin
              err_q     <= 1'b0;
              mem_req   <= 1'b1;
              mem_we    <= req_store;
              mem_be    <= access_be(req_funct3, req_addr[1:0]);
              mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_wdata <= req_store ? store_data(req_funct3, req_wdata) : 32'h0;
              state     <= ST_REQ;
`ifdef LSU_TIMEOUT_EN
              cnt       <= '0;
`endif
            end
          end
        end
        ST_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= ST_WAIT;
`ifdef LSU_TIMEOUT_EN
            cnt     <= '0;
          end else if (expired) begin
            mem_req  <= 1'b0;
            err_q    <= 1'b1;
            rsp_data <= '0;
            state    <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
`endif
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            rsp_data <= store_q ? 32'h0 : load_data;
            state    <= ST_RESP;
`ifdef LSU_TIMEOUT_EN
          end else if (expired) begin
            err_q    <= 1'b1;
            rsp_data <= '0;
            state    <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
`endif
          end
        end
        ST_RESP: begin
          rsp_valid <= 1'b1;
          rsp_err   <= err_q;
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          mem_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule
